// File: rtl/calc_pkg.sv
// Shared types and BCD helpers for the operand entry controller.
package calc_pkg;

    typedef enum logic {
        EDIT   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Out-of-range inputs fold to 0 so a digit can never leave 0..9.
    function automatic bcd_t bcd_inc(input bcd_t d);
        bcd_t r;
        if (d >= BCD_MAX) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd_t bcd_dec(input bcd_t d);
        bcd_t r;
        if ((d == 4'd0) || (d > BCD_MAX)) begin
            r = BCD_MAX;
        end else begin
            r = d - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/operand_entry_ctrl_btn_pulse.sv
// Button conditioner: 2-flop synchronizer followed by a rising-edge detector.
module btn_pulse (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchronizer chain plus the delayed copy used for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign pulse = sync2_r & ~prev_r;

endmodule

// File: rtl/operand_entry_ctrl.sv
// BCD operand entry controller: edit digits with buttons, commit with a valid/ready handshake.
// Optional cursor blink is enabled by defining DIGIT_BLINK_EN.
module operand_entry_ctrl
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_up,
    input  logic                          btn_down,
    input  logic                          btn_left,
    input  logic                          btn_right,
    input  logic                          btn_enter,
    input  logic                          op_ready,
    output logic [4*NUM_DIGITS-1:0]       digits,
    output logic [$clog2(NUM_DIGITS)-1:0] cursor,
    output logic                          op_valid,
    output logic [NUM_DIGITS-1:0]         blink_mask
);

    localparam int CW = $clog2(NUM_DIGITS);

    logic up_s;
    logic down_s;
    logic left_s;
    logic right_s;
    logic enter_s;

    btn_pulse u_up    (.clk(clk), .rst(rst), .btn(btn_up),    .pulse(up_s));
    btn_pulse u_down  (.clk(clk), .rst(rst), .btn(btn_down),  .pulse(down_s));
    btn_pulse u_left  (.clk(clk), .rst(rst), .btn(btn_left),  .pulse(left_s));
    btn_pulse u_right (.clk(clk), .rst(rst), .btn(btn_right), .pulse(right_s));
    btn_pulse u_enter (.clk(clk), .rst(rst), .btn(btn_enter), .pulse(enter_s));

    state_t          state_r;
    bcd_t            digit_r [NUM_DIGITS];
    logic [CW-1:0]   cursor_r;
    logic            op_valid_r;

    // Edit/commit FSM; the priority chain enter > up > down > left > right drops the rest.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= EDIT;
            cursor_r   <= '0;
            op_valid_r <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_r[i] <= 4'd0;
            end
        end else begin
            case (state_r)
                EDIT: begin
                    if (enter_s) begin
                        state_r    <= COMMIT;
                        op_valid_r <= 1'b1;
                    end else if (up_s) begin
                        digit_r[cursor_r] <= bcd_inc(digit_r[cursor_r]);
                    end else if (down_s) begin
                        digit_r[cursor_r] <= bcd_dec(digit_r[cursor_r]);
                    end else if (left_s) begin
                        if (cursor_r == CW'(NUM_DIGITS - 1)) begin
                            cursor_r <= '0;
                        end else begin
                            cursor_r <= cursor_r + CW'(1);
                        end
                    end else if (right_s) begin
                        if (cursor_r == '0) begin
                            cursor_r <= CW'(NUM_DIGITS - 1);
                        end else begin
                            cursor_r <= cursor_r - CW'(1);
                        end
                    end else begin
                        op_valid_r <= 1'b0;
                    end
                end
                COMMIT: begin
                    if (op_ready) begin
                        state_r    <= EDIT;
                        op_valid_r <= 1'b0;
                        cursor_r   <= '0;
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            digit_r[i] <= 4'd0;
                        end
                    end else begin
                        op_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= EDIT;
                    op_valid_r <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digits
        assign digits[4*g +: 4] = digit_r[g];
    end

    assign cursor   = cursor_r;
    assign op_valid = op_valid_r;

`ifdef DIGIT_BLINK_EN
    logic        cursor_move_s;
    logic [31:0] blink_cnt_r;
    logic        blink_off_r;

    // Any cursor change (including the post-commit return to 0) restarts the blink.
    always_comb begin
        cursor_move_s = 1'b0;
        if (state_r == EDIT) begin
            cursor_move_s = ~enter_s & ~up_s & ~down_s & (left_s | right_s);
        end else begin
            cursor_move_s = op_ready;
        end
    end

    // Blink phase counter: toggles every BLINK_DIV cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_r <= 32'd0;
            blink_off_r <= 1'b0;
        end else if (cursor_move_s) begin
            blink_cnt_r <= 32'd0;
            blink_off_r <= 1'b0;
        end else if (blink_cnt_r >= 32'(BLINK_DIV - 1)) begin
            blink_cnt_r <= 32'd0;
            blink_off_r <= ~blink_off_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + 32'd1;
        end
    end

    // Blank the cursor digit only during the off phase while editing.
    always_comb begin
        blink_mask = '0;
        if (blink_off_r && (state_r == EDIT)) begin
            blink_mask = NUM_DIGITS'(1) << cursor_r;
        end else begin
            blink_mask = '0;
        end
    end
`else
    assign blink_mask = '0;
`endif

endmodule

// File: doc/operand_entry_ctrl.md
OPERAND_ENTRY_CTRL -- requirements
Module: operand_entry_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of BCD digits edited (2..8).
REQ-002 Parameter BLINK_DIV, default 25_000_000, clk cycles per cursor-blink half-period (used only when DIGIT_BLINK_EN is defined).
REQ-003 clk  input  1  system clock, all state on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 btn_up / btn_down / btn_left / btn_right / btn_enter  input  1 each  raw, asynchronous push-button levels.
REQ-006 op_ready  input  1  consumer accepts the operand.
REQ-007 digits  output  4*NUM_DIGITS  BCD operand; digit 0 is in bits [3:0] and is the least significant.
REQ-008 cursor  output  $clog2(NUM_DIGITS)  index of the digit under edit.
REQ-009 op_valid  output  1  committed operand is offered on digits.
REQ-010 blink_mask  output  NUM_DIGITS  one-hot display-blank mask for the cursor digit.

Function
REQ-011 Each button SHALL pass a 2-flop synchronizer and a rising-edge detector, giving a one-clk pulse per press; total latency from pin edge to state update is 3 clk.
REQ-012 The FSM SHALL have exactly two states, EDIT and COMMIT.
REQ-013 In EDIT, an up pulse SHALL set digits[cursor] to (d+1) mod 10 (9->0); other digits are unchanged.
REQ-014 In EDIT, a down pulse SHALL set digits[cursor] to (d+9) mod 10 (0->9).
REQ-015 In EDIT, a left pulse SHALL set cursor to (cursor+1) mod NUM_DIGITS, and a right pulse to (cursor-1) mod NUM_DIGITS, so both directions wrap.
REQ-016 If several pulses arrive in one cycle, priority SHALL be enter > up > down > left > right; lower-priority pulses that cycle are discarded.
REQ-017 In EDIT, an enter pulse SHALL move to COMMIT and assert op_valid on the next clk.
REQ-018 In COMMIT, op_valid SHALL stay high and digits and cursor SHALL stay stable; all button pulses are ignored.
REQ-019 In COMMIT, on a cycle with op_valid & op_ready, the FSM SHALL return to EDIT, clear all digits to 0 and set cursor to 0 on the following clk.
REQ-020 op_ready while in EDIT SHALL have no effect.
REQ-021 Digit registers SHALL never hold a value above 9.

Reset
REQ-022 While rst is low: state=EDIT, digits=0, cursor=0, op_valid=0, blink_mask=0, synchronizer and edge flops=0, blink counter=0.
REQ-023 Reset asserted mid-COMMIT SHALL drop op_valid immediately (asynchronously), with no handshake completion.
REQ-024 The first clk after rst rises SHALL NOT produce a pulse from a button already held during reset.

Configuration
REQ-025 Macro DIGIT_BLINK_EN: when defined, a counter toggles a blink phase every BLINK_DIV clk; blink_mask is one-hot at cursor during the off phase in EDIT, and 0 otherwise.
REQ-026 Without DIGIT_BLINK_EN, blink_mask SHALL be tied to 0 and no blink counter SHALL exist.
REQ-027 With DIGIT_BLINK_EN defined, any cursor move SHALL restart the blink phase at on (mask=0) and clear the counter.

Structure
REQ-028 Shared package calc_pkg SHALL hold the state enum (EDIT, COMMIT), the BCD digit type (4 bits) and the constant BCD_MAX=9.
REQ-029 One sub-module btn_pulse (synchronizer plus rising-edge detector, one per button) SHALL be instantiated five times.

Verification
REQ-030 Reset, 3x up at cursor 0 -> digits=0x0003.
REQ-031 Digit 0 at 9, up -> digit 0 = 0 with no carry into digit 1; then down -> 9.
REQ-032 cursor=3 (NUM_DIGITS=4), left -> cursor=0; right -> cursor=3.
REQ-033 digits=0x1234, enter with op_ready=0 for 5 clk -> op_valid high and digits=0x1234 throughout, up presses ignored; op_ready=1 -> next clk op_valid=0, digits=0, cursor=0.
REQ-034 up and left pulses in the same cycle -> only the digit increments and cursor is unchanged; enter and up together -> COMMIT with the digit unchanged.
REQ-035 rst low during COMMIT -> op_valid=0 and digits=0 without a clk edge; with DIGIT_BLINK_EN and BLINK_DIV=4 -> blink_mask toggles every 4 clk in EDIT.
